// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: Decode-to-Execute pipeline register with flush bubbles and
// saturating bubble-cause counters.  Rev 1.0
`default_nettype none

module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             FlushE,
  input  logic             PCSrcE,
  input  logic             CntClr,
  input  logic             ValidD,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  output logic             RegWriteE,
  output logic [1:0]       ResultSrcE,
  output logic             MemWriteE,
  output logic             JumpE,
  output logic             BranchE,
  output logic             ALUSrcE,
  output logic [2:0]       ALUControlE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             ValidE,
  output logic [CNT_W-1:0] CtrlFlushCnt,
  output logic [CNT_W-1:0] LoadUseCnt
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm_ext;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } ex_bundle_t;

  ex_bundle_t       pipe_d, pipe_q;
  logic [CNT_W-1:0] ctrl_cnt_d, ctrl_cnt_q;
  logic [CNT_W-1:0] load_cnt_d, load_cnt_q;

  always_comb begin
    // A bubble is an all-zero bundle: x0 indices, no write/branch/load side effects.
    pipe_d     = '0;
    ctrl_cnt_d = ctrl_cnt_q;
    load_cnt_d = load_cnt_q;
    if (!FlushE) begin
      pipe_d.valid       = ValidD;
      pipe_d.reg_write   = RegWriteD;
      pipe_d.result_src  = ResultSrcD;
      pipe_d.mem_write   = MemWriteD;
      pipe_d.jump        = JumpD;
      pipe_d.branch      = BranchD;
      pipe_d.alu_src     = ALUSrcD;
      pipe_d.alu_control = ALUControlD;
      pipe_d.rd1         = RD1D;
      pipe_d.rd2         = RD2D;
      pipe_d.pc          = PCD;
      pipe_d.pc_plus4    = PCPlus4D;
      pipe_d.imm_ext     = ImmExtD;
      pipe_d.rs1         = Rs1D;
      pipe_d.rs2         = Rs2D;
      pipe_d.rd          = RdD;
    end
    // Clear beats increment; a taken branch claims a coincident load-use bubble.
    if (CntClr) begin
      ctrl_cnt_d = '0;
      load_cnt_d = '0;
    end else if (FlushE && PCSrcE) begin
      if (ctrl_cnt_q != c_CNT_MAX) ctrl_cnt_d = ctrl_cnt_q + c_CNT_ONE;
    end else if (FlushE) begin
      if (load_cnt_q != c_CNT_MAX) load_cnt_d = load_cnt_q + c_CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q     <= '0;
      ctrl_cnt_q <= '0;
      load_cnt_q <= '0;
    end else begin
      pipe_q     <= pipe_d;
      ctrl_cnt_q <= ctrl_cnt_d;
      load_cnt_q <= load_cnt_d;
    end
  end

  assign ValidE       = pipe_q.valid;
  assign RegWriteE    = pipe_q.reg_write;
  assign ResultSrcE   = pipe_q.result_src;
  assign MemWriteE    = pipe_q.mem_write;
  assign JumpE        = pipe_q.jump;
  assign BranchE      = pipe_q.branch;
  assign ALUSrcE      = pipe_q.alu_src;
  assign ALUControlE  = pipe_q.alu_control;
  assign RD1E         = pipe_q.rd1;
  assign RD2E         = pipe_q.rd2;
  assign PCE          = pipe_q.pc;
  assign PCPlus4E     = pipe_q.pc_plus4;
  assign ImmExtE      = pipe_q.imm_ext;
  assign Rs1E         = pipe_q.rs1;
  assign Rs2E         = pipe_q.rs2;
  assign RdE          = pipe_q.rd;
  assign CtrlFlushCnt = ctrl_cnt_q;
  assign LoadUseCnt   = load_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: randomized and directed checks of id_ex_pipe_reg against
// a transaction-level model (bundle copy or bubble, integer saturating counters).
`default_nettype none

module tb_id_ex_pipe_reg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int BW    = 186;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic FlushE = 1'b0, PCSrcE = 1'b0, CntClr = 1'b0;
  logic ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]      ResultSrcD;
  logic [2:0]      ALUControlD;
  logic [XLEN-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0]      Rs1D, Rs2D, RdD;

  logic ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]      ResultSrcE;
  logic [2:0]      ALUControlE;
  logic [XLEN-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]      Rs1E, Rs2E, RdE;
  logic [CNT_W-1:0] CtrlFlushCnt, LoadUseCnt;

  logic [BW-1:0] din, dout;
  assign din  = {ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD,
                 ALUControlD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD};
  assign dout = {ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
                 ALUControlE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE};

  id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .FlushE(FlushE), .PCSrcE(PCSrcE), .CntClr(CntClr),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
    .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
    .CtrlFlushCnt(CtrlFlushCnt), .LoadUseCnt(LoadUseCnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [BW-1:0] exp_bundle = '0;
  int exp_cf = 0;
  int exp_lu = 0;

  task automatic randomize_d();
    ValidD      = 1'($urandom);
    RegWriteD   = 1'($urandom);
    ResultSrcD  = 2'($urandom_range(0, 2));
    MemWriteD   = 1'($urandom);
    JumpD       = 1'($urandom);
    BranchD     = 1'($urandom);
    ALUSrcD     = 1'($urandom);
    ALUControlD = 3'($urandom);
    RD1D        = $urandom;
    RD2D        = $urandom;
    PCD         = $urandom & 32'hFFFF_FFFC;
    PCPlus4D    = PCD + 32'd4;
    ImmExtD     = $urandom;
    Rs1D        = 5'($urandom_range(1, 31));
    Rs2D        = 5'($urandom_range(1, 31));
    RdD         = 5'($urandom_range(1, 31));
  endtask

  task automatic check_bits(string tag, logic [BW-1:0] obs, logic [BW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_int(string tag, int obs, int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(string tag);
    check_bits({tag, ".bundle"}, dout, exp_bundle);
    check_int({tag, ".ctrlcnt"}, int'(CtrlFlushCnt), exp_cf);
    check_int({tag, ".loadcnt"}, int'(LoadUseCnt), exp_lu);
  endtask

  // One clock edge: model decides bubble-or-copy and counter update from the
  // values presented at the edge, then the DUT is sampled 1 time unit later.
  task automatic step(string tag, logic f, logic p, logic c);
    FlushE = f;
    PCSrcE = p;
    CntClr = c;
    @(posedge clk);
    exp_bundle = f ? '0 : din;
    if (c) begin
      exp_cf = 0;
      exp_lu = 0;
    end else if (f && p) begin
      exp_cf = (exp_cf < CMAX) ? exp_cf + 1 : CMAX;
    end else if (f) begin
      exp_lu = (exp_lu < CMAX) ? exp_lu + 1 : CMAX;
    end
    #1;
    check_all(tag);
    randomize_d();
  endtask

  task automatic model_reset();
    exp_bundle = '0;
    exp_cf     = 0;
    exp_lu     = 0;
  endtask

  initial begin
    randomize_d();
    ValidD = 1'b1;
    #2;
    check_all("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    // Pass-through of a load
    randomize_d();
    RD1D = 32'h1234_5678; RdD = 5'd5; ResultSrcD = 2'b01; ValidD = 1'b1;
    step("passthru", 1'b0, 1'b0, 1'b0);
    check_int("passthru.rd1", int'(RD1E), int'(32'h1234_5678));
    check_int("passthru.rd", int'(RdE), 5);
    check_int("passthru.resultsrc", int'(ResultSrcE), 1);
    check_int("passthru.valid", int'(ValidE), 1);

    // Load-use bubble with a valid load in D
    ValidD = 1'b1; ResultSrcD = 2'b01; RegWriteD = 1'b1; MemWriteD = 1'b1;
    step("loaduse", 1'b1, 1'b0, 1'b0);
    check_int("loaduse.valid", int'(ValidE), 0);
    check_int("loaduse.load_ind", int'(ResultSrcE[0]), 0);
    check_int("loaduse.lucnt", int'(LoadUseCnt), 1);

    // Branch flush coincident with load-use, three in a row
    for (int i = 0; i < 3; i++) step("ctrlflush", 1'b1, 1'b1, 1'b0);
    check_int("ctrlflush.cfcnt", int'(CtrlFlushCnt), 3);
    check_int("ctrlflush.lucnt", int'(LoadUseCnt), 1);

    // Randomized mix
    for (int i = 0; i < 60; i++)
      step("random", 1'($urandom_range(0, 2) == 0), 1'($urandom),
           1'($urandom_range(0, 15) == 0));

    // Saturation then clear-over-increment
    step("preclr", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step("saturate", 1'b1, 1'b0, 1'b0);
    check_int("saturate.lucnt", int'(LoadUseCnt), CMAX);
    for (int i = 0; i < 18; i++) step("saturate_cf", 1'b1, 1'b1, 1'b0);
    check_int("saturate.cfcnt", int'(CtrlFlushCnt), CMAX);
    step("clr_wins", 1'b1, 1'b0, 1'b1);
    check_int("clr_wins.lucnt", int'(LoadUseCnt), 0);
    check_int("clr_wins.cfcnt", int'(CtrlFlushCnt), 0);

    // Reset mid-stream, asserted asynchronously between edges
    for (int i = 0; i < 5; i++) step("stream", 1'b0, 1'b0, 1'b0);
    step("stream_fl", 1'b1, 1'b1, 1'b0);
    step("stream_fl", 1'b1, 1'b0, 1'b0);
    FlushE = 1'b0;
    ValidD = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++)
      step("random_tail", 1'($urandom_range(0, 2) == 0), 1'($urandom),
           1'($urandom_range(0, 15) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Decode-to-Execute pipeline register of the five-stage RV32I core.
- Captures decoded control, register-file operands, immediate and PC values from the Decode stage each cycle. Presents them to Execute, and supplies Rs1E/Rs2E/RdE/ResultSrcE to the hazard unit.
- Consumes FlushE from the hazard unit to insert bubbles.
- Keeps saturating counters of branch-flush and load-use bubbles for performance debug.

Parameters:
- XLEN, 32, datapath width of operands, PC and immediate.
- CNT_W, 16, width of each bubble counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- FlushE  input  1  from hazard unit; insert bubble into E this edge
- PCSrcE  input  1  branch/jump taken in E; classifies the flush cause
- CntClr  input  1  synchronous clear of both bubble counters
- ValidD  input  1  Decode holds a real instruction (0 after FlushD)
- RegWriteD  input  1  register write enable
- ResultSrcD  input  2  result select (00 ALU, 01 memory, 10 PC+4)
- MemWriteD, JumpD, BranchD, ALUSrcD  input  1 each  control bits
- ALUControlD  input  3  ALU operation
- RD1D, RD2D  input  XLEN  register-file read data
- PCD, PCPlus4D, ImmExtD  input  XLEN  PC, PC+4, sign-extended immediate
- Rs1D, Rs2D, RdD  input  5  register indices
- The matching E-suffixed outputs (RegWriteE … RdE)  output  same widths  registered copies of the D-suffixed inputs
- ValidE  output  1  Execute holds a real instruction
- CtrlFlushCnt  output  CNT_W  bubbles caused by taken branch/jump
- LoadUseCnt  output  CNT_W  bubbles caused by load-use stall

Behaviour:
- Reset: every output, including both counters and ValidE, goes to 0 immediately on rst high, independent of clk. Outputs hold 0 while rst is high. The first capture happens on the first rising edge after rst falls.
- Latency: exactly 1 cycle; no enable or stall input, so the register captures on every edge.
- Normal edge (FlushE=0): all E outputs take their D inputs; ValidE takes ValidD.
- Flush edge (FlushE=1): all E outputs are cleared to 0, including data, PC and immediate fields, and ValidE=0.
  - Zeroing RdE/Rs1E/Rs2E guarantees the hazard unit sees register x0, so no false forwarding or stall occurs.
  - Zeroing RegWriteE/MemWriteE/BranchE/JumpE guarantees there are no architectural side effects.
- ResultSrcE[0] is the load indicator the hazard unit consumes; a flushed bubble must present 0 on it.
- Counters update on each edge with the following priority:
  - CntClr=1: both counters go to 0. Clear wins over a simultaneous increment.
  - Else FlushE=1 and PCSrcE=1: CtrlFlushCnt increments by 1.
  - Else FlushE=1 and PCSrcE=0: LoadUseCnt increments by 1.
  - Each counter saturates at all-ones; no wrap.
- Simultaneous load-use and taken branch (FlushE=1, PCSrcE=1): the bubble counts as a control flush only.
- Back-to-back flushes: each flushed cycle counts once and each inserts one bubble.
- FlushE or PCSrcE being X/Z during reset has no effect: reset dominates.
- Reset asserted mid-operation: counters and pipeline contents are lost; no partial state is retained.

Test Plan:
- Reset: drive all D inputs nonzero, pulse rst asynchronously mid-cycle → all E outputs, ValidE and both counters read 0 before the next clk edge.
- Pass-through: FlushE=0, RD1D=0x1234_5678, RdD=5, ResultSrcD=01, ValidD=1 → one edge later RD1E=0x1234_5678, RdE=5, ResultSrcE=01, ValidE=1.
- Load-use bubble: FlushE=1, PCSrcE=0 with a valid load in D → next edge all E fields 0, ValidE=0, LoadUseCnt=1, CtrlFlushCnt=0.
- Branch flush with coincident load-use: FlushE=1, PCSrcE=1 for 3 consecutive edges → CtrlFlushCnt=3, LoadUseCnt unchanged.
- Saturation and clear: with CNT_W=4, apply 20 load-use flushes → LoadUseCnt=15. Then apply CntClr=1 together with FlushE=1 → both counters 0 after the edge.
- Reset mid-stream: after 5 captured instructions and 2 flushes, assert rst → all outputs 0. After release, the first edge with FlushE=0 captures the D inputs normally.
